// File: rtl/sram_arb_pkg.sv
// ============================================================================
// Package  : sram_arb_pkg
// Brief    : Shared state and grant encodings for the SRAM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_e;

    typedef enum logic {
        GNT_SCAN = 1'b0,
        GNT_HOST = 1'b1
    } grant_e;

endpackage

`default_nettype wire

// File: rtl/sram_arb_pick.sv
// ============================================================================
// Module   : sram_arb_pick
// Brief    : Scan-over-host priority pick; with SRAM_ARB_STARVE_GUARD_EN the
//            host wins once SCAN_BURST_MAX scan grants passed it by.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int SCAN_BURST_MAX = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scan_req_i,
    input  logic host_req_i,
    input  logic take_i,
    output logic host_gnt_o
);

    grant_e w_gnt;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int c_burst_w = $clog2(SCAN_BURST_MAX + 1);
    localparam logic [c_burst_w-1:0] c_burst_max = c_burst_w'(SCAN_BURST_MAX);

    logic [c_burst_w-1:0] burst_q, burst_d;
    logic                 w_host_wins;

    assign w_host_wins = host_req_i && (burst_q == c_burst_max);

    always_comb begin
        w_gnt   = (scan_req_i && !w_host_wins) ? GNT_SCAN : GNT_HOST;
        burst_d = burst_q;
        if (take_i) begin
            // Only scan grants that made a waiting host stand aside count.
            if ((w_gnt == GNT_HOST) || !host_req_i) begin
                burst_d = '0;
            end else if (burst_q != c_burst_max) begin
                burst_d = burst_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{clk, reset_n, take_i, host_req_i, (SCAN_BURST_MAX > 0)};

    always_comb begin
        w_gnt = scan_req_i ? GNT_SCAN : GNT_HOST;
    end
`endif

    assign host_gnt_o = (w_gnt == GNT_HOST);

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module   : sram_arbiter
// Brief    : Shares one async SRAM port between a scan reader and a host
//            read/write port. Optional guard macro: SRAM_ARB_STARVE_GUARD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 18,
    parameter int DATA_WIDTH     = 16,
    parameter int WAIT_CYCLES    = 2,
    parameter int SCAN_BURST_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  scan_req,
    input  logic [ADDR_WIDTH-1:0] scan_addr,
    output logic                  scan_ack,
    output logic [DATA_WIDTH-1:0] scan_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  busy,
    output logic                  read_n,
    output logic                  write_n,
    output logic                  ce_n,
    output logic [ADDR_WIDTH-1:0] address_bus,
    output logic [DATA_WIDTH-1:0] data_bus_in,
    input  logic [DATA_WIDTH-1:0] data_bus_out
);

    localparam int c_cnt_w = $clog2(WAIT_CYCLES + 2);
    // Counter holds remaining ACCESS cycles minus one; writes get one extra.
    localparam logic [c_cnt_w-1:0] c_rd_load = c_cnt_w'(WAIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_wr_load = c_cnt_w'(WAIT_CYCLES);

    state_e                state_q, state_d;
    grant_e                gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic                  read_n_q, read_n_d;
    logic                  write_n_q, write_n_d;
    logic                  ce_n_q, ce_n_d;
    logic                  scan_ack_q, scan_ack_d;
    logic                  host_ack_q, host_ack_d;
    logic [DATA_WIDTH-1:0] scan_rdata_q, scan_rdata_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                  w_take;
    logic                  w_host_gnt;

    assign w_take = (state_q == IDLE) && (scan_req || host_req);

    sram_arb_pick #(
        .SCAN_BURST_MAX (SCAN_BURST_MAX)
    ) u_pick (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_req_i (scan_req),
        .host_req_i (host_req),
        .take_i     (w_take),
        .host_gnt_o (w_host_gnt)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        read_n_d     = 1'b1;
        write_n_d    = 1'b1;
        ce_n_d       = 1'b1;
        scan_ack_d   = 1'b0;
        host_ack_d   = 1'b0;
        scan_rdata_d = scan_rdata_q;
        host_rdata_d = host_rdata_q;
        case (state_q)
            IDLE: begin
                if (w_take) begin
                    state_d = SETUP;
                    if (w_host_gnt) begin
                        gnt_d   = GNT_HOST;
                        we_d    = host_we;
                        addr_d  = host_addr;
                        wdata_d = host_wdata;
                    end else begin
                        gnt_d   = GNT_SCAN;
                        we_d    = 1'b0;
                        addr_d  = scan_addr;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                cnt_d     = we_q ? c_wr_load : c_rd_load;
                ce_n_d    = 1'b0;
                read_n_d  = we_q;
                write_n_d = ~we_q;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    if (gnt_q == GNT_SCAN) begin
                        scan_ack_d   = 1'b1;
                        scan_rdata_d = data_bus_out;
                    end else begin
                        host_ack_d = 1'b1;
                        if (!we_q) begin
                            host_rdata_d = data_bus_out;
                        end
                    end
                end else begin
                    cnt_d     = cnt_q - 1'b1;
                    ce_n_d    = 1'b0;
                    read_n_d  = we_q;
                    write_n_d = ~we_q;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_SCAN;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            read_n_q     <= 1'b1;
            write_n_q    <= 1'b1;
            ce_n_q       <= 1'b1;
            scan_ack_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            scan_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            read_n_q     <= read_n_d;
            write_n_q    <= write_n_d;
            ce_n_q       <= ce_n_d;
            scan_ack_q   <= scan_ack_d;
            host_ack_q   <= host_ack_d;
            scan_rdata_q <= scan_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign read_n      = read_n_q;
    assign write_n     = write_n_q;
    assign ce_n        = ce_n_q;
    assign address_bus = addr_q;
    assign data_bus_in = wdata_q;
    assign scan_ack    = scan_ack_q;
    assign host_ack    = host_ack_q;
    assign scan_rdata  = scan_rdata_q;
    assign host_rdata  = host_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Self-checking bench for sram_arbiter (WAIT_CYCLES 2 and 1 builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int W   = 2;
    localparam int SBM = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance (WAIT_CYCLES = 2)
    logic          scan_req = 1'b0, host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] scan_addr = '0, host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          scan_ack, host_ack, busy, read_n, write_n, ce_n;
    logic [DW-1:0] scan_rdata, host_rdata, data_bus_in, data_bus_out;
    logic [AW-1:0] address_bus;

    // Minimum-wait instance (WAIT_CYCLES = 1), scan port only
    logic          s1_req = 1'b0;
    logic [AW-1:0] s1_addr = '0;
    logic          s1_ack, h1_ack, busy1, read_n1, write_n1, ce_n1;
    logic [DW-1:0] s1_rdata, h1_rdata, dbi1, dbo1;
    logic [AW-1:0] addr1;

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(W), .SCAN_BURST_MAX(SBM)) dut (
        .clk(clk), .reset_n(reset_n),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_ack(scan_ack), .scan_rdata(scan_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata), .busy(busy),
        .read_n(read_n), .write_n(write_n), .ce_n(ce_n),
        .address_bus(address_bus), .data_bus_in(data_bus_in), .data_bus_out(data_bus_out)
    );

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(1), .SCAN_BURST_MAX(SBM)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .scan_req(s1_req), .scan_addr(s1_addr), .scan_ack(s1_ack), .scan_rdata(s1_rdata),
        .host_req(1'b0), .host_we(1'b0), .host_addr({AW{1'b0}}), .host_wdata({DW{1'b0}}),
        .host_ack(h1_ack), .host_rdata(h1_rdata), .busy(busy1),
        .read_n(read_n1), .write_n(write_n1), .ce_n(ce_n1),
        .address_bus(addr1), .data_bus_in(dbi1), .data_bus_out(dbo1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- SRAM environment and reference memory ----------------
    logic [DW-1:0] sram_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem  [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        return DW'(a) ^ 16'h5A3C;
    endfunction
    function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : init_pat(a);
    endfunction
    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
    endfunction
    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 18'h3FFFF;
        return AW'($urandom_range(0, 63));
    endfunction

    assign data_bus_out = (!ce_n && !read_n) ? sram_rd(address_bus) : 16'hDEAD;
    assign dbo1         = (!ce_n1 && !read_n1) ? sram_rd(addr1) : 16'hDEAD;

    always @(negedge clk) begin
        if (reset_n && !ce_n && !write_n) sram_mem[address_bus] = data_bus_in;
    end

    // ---------------- Transaction-level reference monitor ----------------
    typedef struct {
        bit            host;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gcyc;
    } acc_t;

    acc_t pend[$];
    int   burst = 0;
    int   rd_run = 0, wr_run = 0, ce_run = 0;
    bit   bad_hold = 1'b0, overlap = 1'b0;
    int   n_scan_ack = 0, n_host_ack = 0, scan_at_host = 0;

    always @(negedge clk) begin : mon
        acc_t a;
        bit   hw;
        if (!reset_n) begin
            pend.delete();
            burst = 0; rd_run = 0; wr_run = 0; ce_run = 0;
            bad_hold = 1'b0; overlap = 1'b0;
        end else begin
            if (!read_n) rd_run++;
            if (!write_n) wr_run++;
            if (!ce_n) ce_run++;
            if (!read_n && !write_n) overlap = 1'b1;
            if (!ce_n && pend.size() > 0) begin
                if (address_bus !== pend[0].addr) bad_hold = 1'b1;
                if (pend[0].we && data_bus_in !== pend[0].wdata) bad_hold = 1'b1;
            end
            if (!busy && (scan_req || host_req)) begin
                hw = 1'b0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
                hw = host_req && (burst == SBM);
`endif
                a.host  = !scan_req || hw;
                a.we    = a.host ? host_we : 1'b0;
                a.addr  = a.host ? host_addr : scan_addr;
                a.wdata = host_wdata;
                a.gcyc  = cyc;
`ifdef SRAM_ARB_STARVE_GUARD_EN
                if (a.host || !host_req) burst = 0;
                else if (burst < SBM) burst++;
`endif
                pend.push_back(a);
            end
            if (scan_ack || host_ack) begin
                if (scan_ack) n_scan_ack++;
                if (host_ack) begin
                    n_host_ack++;
                    scan_at_host = n_scan_ack;
                end
                check("pend_cnt", pend.size(), 1);
                if (pend.size() > 0) begin
                    a = pend.pop_front();
                    check("ack_port", {scan_ack, host_ack}, a.host ? 2'b01 : 2'b10);
                    check("ack_lat", cyc - a.gcyc, 2 + (a.we ? W + 1 : W));
                    check("rd_strobe_len", rd_run, a.we ? 0 : W);
                    check("wr_strobe_len", wr_run, a.we ? W + 1 : 0);
                    check("ce_len", ce_run, a.we ? W + 1 : W);
                    check("bus_hold", {overlap, bad_hold}, 2'b00);
                    if (!a.host) check("scan_rdata", scan_rdata, ref_rd(a.addr));
                    else if (a.we) ref_mem[a.addr] = a.wdata;
                    else check("host_rdata", host_rdata, ref_rd(a.addr));
                end
                rd_run = 0; wr_run = 0; ce_run = 0;
                bad_hold = 1'b0; overlap = 1'b0;
            end
        end
    end

    // ---------------- Requester helpers ----------------
    task automatic wait_ack(input bit host, input int bound, output int at);
        at = -1;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk);
            if (host ? host_ack : scan_ack) begin
                at = cyc;
                break;
            end
        end
        if (host) check("host_ack_seen", at >= 0, 1'b1);
        else      check("scan_ack_seen", at >= 0, 1'b1);
        @(posedge clk); #1;
        if (host) host_req = 1'b0;
        else      scan_req = 1'b0;
    endtask

    task automatic host_go(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, at, at_s, at_h, lo, h0, s0;
        sram_mem[18'h10] = 16'hA5A5;
        ref_mem[18'h10]  = 16'hA5A5;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {read_n, write_n, ce_n}, 3'b111);
        check("rst_addr", address_bus, 0);
        check("rst_wdata", data_bus_in, 0);
        check("rst_acks_busy", {scan_ack, host_ack, busy}, 3'b000);
        check("rst_rdata", {scan_rdata, host_rdata}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Scan read of preloaded word
        k = cyc; scan_addr = 18'h00010; scan_req = 1'b1;
        wait_ack(1'b0, 20, at);
        check("scan_lat", at - k, 4);
        check("scan_a5a5", scan_rdata, 16'hA5A5);

        // Minimum wait build
        k = cyc; s1_addr = 18'h00010; s1_req = 1'b1; lo = 0; at = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!read_n1) lo++;
            if (s1_ack) begin
                at = cyc;
                break;
            end
        end
        check("w1_ack_lat", at - k, 3);
        check("w1_rd_low", lo, 1);
        check("w1_rdata", s1_rdata, 16'hA5A5);
        @(posedge clk); #1;
        s1_req = 1'b0;
        @(negedge clk);
        check("w1_idle", {busy1, write_n1}, 2'b01);
        @(posedge clk); #1;

        // Host write then read at top address
        k = cyc; host_go(1'b1, 18'h3FFFF, 16'h1234);
        wait_ack(1'b1, 20, at);
        check("wr_lat", at - k, 5);
        k = cyc; host_go(1'b0, 18'h3FFFF, 16'h0000);
        wait_ack(1'b1, 20, at);
        check("rd_lat", at - k, 4);
        check("host_1234", host_rdata, 16'h1234);

        // Simultaneous requests
        scan_addr = 18'h00021; scan_req = 1'b1; host_go(1'b0, 18'h3FFFF, 16'h0);
        fork
            wait_ack(1'b0, 20, at_s);
            wait_ack(1'b1, 40, at_h);
        join
        check("simul_gap", at_h - at_s, W + 3);

        // Starvation: scan keeps re-requesting while host waits
        s0 = n_scan_ack; h0 = n_host_ack;
        host_go(1'b0, 18'h00007, 16'h0);
        fork
            wait_ack(1'b1, 600, at_h);
            begin
                int n = 0;
                while (n < 50 && n_host_ack == h0) begin
                    scan_addr = AW'($urandom_range(0, 63)); scan_req = 1'b1;
                    wait_ack(1'b0, 50, at_s);
                    n++;
                end
            end
        join
`ifdef SRAM_ARB_STARVE_GUARD_EN
        check("guard_scan_first", scan_at_host - s0, SBM);
`else
        check("strict_scan_first", scan_at_host - s0, 50);
`endif

        // Reset in the 2nd ACCESS cycle of a write
        h0 = n_host_ack;
        k = cyc; host_go(1'b1, 18'h20000, 16'hBEEF);
        repeat (3) @(posedge clk); #1;
        reset_n = 1'b0; host_req = 1'b0;
        @(negedge clk);
        check("mid_write_low", {write_n, ce_n}, 2'b00);
        @(negedge clk);
        check("rst_mid_strobes", {read_n, write_n, ce_n}, 3'b111);
        check("rst_mid_busy_ack", {busy, host_ack, scan_ack}, 3'b000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        k = cyc; scan_addr = 18'h00033; scan_req = 1'b1;
        wait_ack(1'b0, 20, at);
        check("post_rst_lat", at - k, 4);
        check("rst_no_host_ack", n_host_ack - h0, 0);

        // Randomised traffic on both ports
        fork
            repeat (60) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
                scan_addr = pick_addr(); scan_req = 1'b1;
                wait_ack(1'b0, 200, at_s);
            end
            repeat (60) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
                host_go(1'($urandom_range(0, 1)), pick_addr(), DW'($urandom));
                wait_ack(1'b1, 200, at_h);
            end
        join
        repeat (4) @(negedge clk);
        check("pend_empty", pend.size(), 0);
        check("final_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
